// File: rtl/gpu_pkg.sv
// Shared types and helpers for the GPU core controllers: FSM state encoding,
// default fetch-address width and the active-lane mask builder.
package gpu_pkg;

    localparam int unsigned DefaultPcWidth = 8;
    localparam int unsigned MaxLanes       = 32;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StRequest = 3'd3,
        StWait    = 3'd4,
        StExecute = 3'd5,
        StUpdate  = 3'd6,
        StDone    = 3'd7
    } core_state_t;

    // Low min(count, lanes) bits set; callers truncate to their lane count.
    function automatic logic [MaxLanes-1:0] lane_mask(input int unsigned count,
                                                      input int unsigned lanes);
        logic [MaxLanes-1:0] mask;
        int unsigned         n;
        n    = (count < lanes) ? count : lanes;
        mask = '0;
        for (int unsigned i = 0; i < MaxLanes; i++) begin
            if (i < n) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/core_block_controller.sv
// Per-core block controller: latches a dispatched block, then steps every lane
// through fetch/decode/memory/execute/update until a RET retires the block.
module core_block_controller
    import gpu_pkg::*;
#(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_WIDTH          = DefaultPcWidth
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [7:0]                             block_id,
    input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count,
    output logic                                   done,
    output logic [7:0]                             block_id_q,
    output logic [THREADS_PER_BLOCK-1:0]           thread_enable,
    output logic [2:0]                             core_state,
    output logic [PC_WIDTH-1:0]                    current_pc,
    output logic                                   instr_req,
    input  logic                                   instr_valid,
    input  logic                                   decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]           lsu_busy,
    input  logic [THREADS_PER_BLOCK*PC_WIDTH-1:0]  next_pc,
    output logic [15:0]                            retired
);

    core_state_t                  state_q, state_d;
    logic                         done_q;
    logic                         instr_req_q;
    logic [7:0]                   latched_id_q;
    logic [THREADS_PER_BLOCK-1:0] thread_enable_q;
    logic [PC_WIDTH-1:0]          pc_q;
    logic [15:0]                  retired_q;

    // Only lane 0 steers the shared fetch address; other lanes' next PCs are unused here.
    logic unused_next_pc;
    assign unused_next_pc = ^next_pc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = (thread_count == '0) ? StDone : StFetch;
            StFetch:   if (instr_valid) state_d = StDecode;
            StDecode:  state_d = StRequest;
            StRequest: state_d = StWait;
            StWait:    if ((lsu_busy & thread_enable_q) == '0) state_d = StExecute;
            StExecute: state_d = StUpdate;
            StUpdate:  state_d = decoded_ret ? StDone : StFetch;
            StDone:    state_d = StDone;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            done_q          <= 1'b0;
            instr_req_q     <= 1'b0;
            latched_id_q    <= '0;
            thread_enable_q <= '0;
            pc_q            <= '0;
            retired_q       <= '0;
        end else begin
            state_q     <= state_d;
            // Flag outputs track the next state so they align with core_state.
            done_q      <= (state_d == StDone);
            instr_req_q <= (state_d == StFetch);
            if (state_q == StIdle && start) begin
                latched_id_q    <= block_id;
                thread_enable_q <= THREADS_PER_BLOCK'(
                    lane_mask(32'(thread_count), THREADS_PER_BLOCK));
                pc_q            <= '0;
            end
            if (state_q == StUpdate) begin
                retired_q <= retired_q + 16'd1;
                if (!decoded_ret) pc_q <= next_pc[PC_WIDTH-1:0];
            end
        end
    end

    assign done          = done_q;
    assign instr_req     = instr_req_q;
    assign block_id_q    = latched_id_q;
    assign thread_enable = thread_enable_q;
    assign core_state    = state_q;
    assign current_pc    = pc_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_core_block_controller.sv
// Directed bench for core_block_controller: each scenario drives hand-built
// vectors and compares outputs against hand-computed values.
module tb_core_block_controller;

    localparam int unsigned Threads = 4;
    localparam int unsigned PcW     = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [7:0]           block_id;
    logic [2:0]           thread_count;
    logic                 done;
    logic [7:0]           block_id_q;
    logic [Threads-1:0]   thread_enable;
    logic [2:0]           core_state;
    logic [PcW-1:0]       current_pc;
    logic                 instr_req;
    logic                 instr_valid;
    logic                 decoded_ret;
    logic [Threads-1:0]   lsu_busy;
    logic [Threads*PcW-1:0] next_pc;
    logic [15:0]          retired;

    int checks   = 0;
    int failures = 0;

    core_block_controller #(
        .THREADS_PER_BLOCK(Threads),
        .PC_WIDTH         (PcW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .block_id     (block_id),
        .thread_count (thread_count),
        .done         (done),
        .block_id_q   (block_id_q),
        .thread_enable(thread_enable),
        .core_state   (core_state),
        .current_pc   (current_pc),
        .instr_req    (instr_req),
        .instr_valid  (instr_valid),
        .decoded_ret  (decoded_ret),
        .lsu_busy     (lsu_busy),
        .next_pc      (next_pc),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".state"},     32'(core_state),    32'd0);
        check_eq({tag, ".done"},      32'(done),          32'd0);
        check_eq({tag, ".instr_req"}, 32'(instr_req),     32'd0);
        check_eq({tag, ".block_id"},  32'(block_id_q),    32'd0);
        check_eq({tag, ".tmask"},     32'(thread_enable), 32'd0);
        check_eq({tag, ".pc"},        32'(current_pc),    32'd0);
        check_eq({tag, ".retired"},   32'(retired),       32'd0);
    endtask

    task automatic do_reset();
        start = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int req_cycles;
        int wait_cycles;
        reset        = 1'b1;
        start        = 1'b0;
        block_id     = 8'd0;
        thread_count = 3'd0;
        instr_valid  = 1'b0;
        decoded_ret  = 1'b0;
        lsu_busy     = '0;
        next_pc      = '0;
        step(2);
        check_reset_vals("rst0");

        // Scenario 1: two-instruction block, second is RET.
        reset        = 1'b0;
        start        = 1'b1;
        block_id     = 8'd5;
        thread_count = 3'd3;
        instr_valid  = 1'b1;
        next_pc      = {8'hAA, 8'hBB, 8'hCC, 8'h01};
        step(1);
        check_eq("s1.latch_state", 32'(core_state),    32'd1);
        check_eq("s1.latch_req",   32'(instr_req),     32'd1);
        check_eq("s1.tmask",       32'(thread_enable), 32'h7);
        check_eq("s1.block_id",    32'(block_id_q),    32'd5);
        check_eq("s1.pc0",         32'(current_pc),    32'd0);
        block_id     = 8'd9;
        thread_count = 3'd1;
        step(1);
        check_eq("s1.decode",      32'(core_state),    32'd2);
        check_eq("s1.decode_req",  32'(instr_req),     32'd0);
        step(1);
        check_eq("s1.request",     32'(core_state),    32'd3);
        step(1);
        check_eq("s1.wait",        32'(core_state),    32'd4);
        step(1);
        check_eq("s1.execute",     32'(core_state),    32'd5);
        step(1);
        check_eq("s1.update",      32'(core_state),    32'd6);
        check_eq("s1.ret_before",  32'(retired),       32'd0);
        step(1);
        check_eq("s1.refetch",     32'(core_state),    32'd1);
        check_eq("s1.pc1",         32'(current_pc),    32'd1);
        check_eq("s1.retired1",    32'(retired),       32'd1);
        decoded_ret = 1'b1;
        step(5);
        check_eq("s1.not_done_11", 32'(done),          32'd0);
        step(1);
        check_eq("s1.done",        32'(done),          32'd1);
        check_eq("s1.done_state",  32'(core_state),    32'd7);
        check_eq("s1.retired2",    32'(retired),       32'd2);
        check_eq("s1.pc_hold",     32'(current_pc),    32'd1);
        check_eq("s1.id_hold",     32'(block_id_q),    32'd5);
        check_eq("s1.tmask_hold",  32'(thread_enable), 32'h7);
        step(3);
        check_eq("s1.absorb",      32'(core_state),    32'd7);
        check_eq("s1.absorb_ret",  32'(retired),       32'd2);

        // Scenario 2: zero-thread block goes straight to DONE.
        decoded_ret = 1'b0;
        instr_valid = 1'b0;
        do_reset();
        check_reset_vals("rst2");
        start        = 1'b1;
        block_id     = 8'd3;
        thread_count = 3'd0;
        step(1);
        check_eq("s2.state",       32'(core_state),    32'd7);
        check_eq("s2.done",        32'(done),          32'd1);
        check_eq("s2.tmask",       32'(thread_enable), 32'd0);
        check_eq("s2.block_id",    32'(block_id_q),    32'd3);
        check_eq("s2.req",         32'(instr_req),     32'd0);
        step(2);
        check_eq("s2.req_later",   32'(instr_req),     32'd0);

        // Scenario 3: busy on a disabled lane is ignored; busy on lane 0 stalls WAIT.
        do_reset();
        start        = 1'b1;
        block_id     = 8'd1;
        thread_count = 3'd2;
        instr_valid  = 1'b1;
        lsu_busy     = 4'b1000;
        next_pc      = {8'h01, 8'h02, 8'h03, 8'h10};
        step(1);
        check_eq("s3.tmask",       32'(thread_enable), 32'h3);
        step(3);
        wait_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_state != 3'd4) break;
            wait_cycles++;
            step(1);
        end
        check_eq("s3.wait_short",  32'(wait_cycles),   32'd1);
        check_eq("s3.exec_short",  32'(core_state),    32'd5);
        step(2);
        check_eq("s3.pc",          32'(current_pc),    32'h10);
        lsu_busy = 4'b0001;
        step(3);
        wait_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_state != 3'd4) break;
            wait_cycles++;
            if (wait_cycles == 4) lsu_busy = '0;
            step(1);
        end
        check_eq("s3.wait_long",   32'(wait_cycles),   32'd4);
        check_eq("s3.exec_long",   32'(core_state),    32'd5);

        // Scenario 4: fetch completes three cycles late.
        do_reset();
        start        = 1'b1;
        block_id     = 8'h21;
        thread_count = 3'd1;
        instr_valid  = 1'b0;
        lsu_busy     = '0;
        next_pc      = {8'h99, 8'h88, 8'h77, 8'h22};
        step(1);
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_state != 3'd1) break;
            if (instr_req) req_cycles++;
            if (req_cycles == 4) instr_valid = 1'b1;
            step(1);
        end
        check_eq("s4.req_cycles",  32'(req_cycles),    32'd4);
        check_eq("s4.decode",      32'(core_state),    32'd2);
        check_eq("s4.req_drop",    32'(instr_req),     32'd0);
        step(5);
        check_eq("s4.pc",          32'(current_pc),    32'h22);
        check_eq("s4.retired",     32'(retired),       32'd1);

        // Scenario 5: reset mid-WAIT, then re-latch with start still high.
        lsu_busy = 4'b0001;
        step(3);
        check_eq("s5.in_wait",     32'(core_state),    32'd4);
        block_id     = 8'h44;
        thread_count = 3'd3;
        reset        = 1'b1;
        step(1);
        check_reset_vals("s5.rst");
        reset    = 1'b0;
        lsu_busy = '0;
        step(1);
        check_eq("s5.relatch",     32'(core_state),    32'd1);
        check_eq("s5.block_id",    32'(block_id_q),    32'h44);
        check_eq("s5.tmask",       32'(thread_enable), 32'h7);
        check_eq("s5.pc",          32'(current_pc),    32'd0);

        // Scenario 6: thread_count above lane count clamps; PC wraps via next_pc.
        do_reset();
        start        = 1'b1;
        block_id     = 8'd6;
        thread_count = 3'd7;
        instr_valid  = 1'b1;
        next_pc      = {8'h11, 8'h22, 8'h33, 8'hFF};
        step(1);
        check_eq("s6.tmask",       32'(thread_enable), 32'hF);
        step(6);
        check_eq("s6.pc_ff",       32'(current_pc),    32'hFF);
        next_pc = {8'h7F, 8'h7F, 8'h7F, 8'h00};
        step(6);
        check_eq("s6.pc_wrap",     32'(current_pc),    32'h00);
        check_eq("s6.retired",     32'(retired),       32'd2);
        check_eq("s6.state",       32'(core_state),    32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_block_controller.md
CORE_BLOCK_CONTROLLER -- requirements
Module: core_block_controller

Interface
REQ-001 SHALL have parameter THREADS_PER_BLOCK, default 4, meaning lanes per core.
REQ-002 SHALL have parameter PC_WIDTH, default 8, meaning program counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high; the dispatcher's per-core reset drives it.
REQ-005 SHALL have port start  input  1  dispatcher block-start level; held high until the dispatcher resets the core.
REQ-006 SHALL have port block_id  input  8  block index, valid while start=1.
REQ-007 SHALL have port thread_count  input  $clog2(THREADS_PER_BLOCK)+1  active lanes for this block.
REQ-008 SHALL have port done  output  1  block finished; returned to the dispatcher.
REQ-009 SHALL have port block_id_q  output  8  latched block index.
REQ-010 SHALL have port thread_enable  output  THREADS_PER_BLOCK  active-lane mask.
REQ-011 SHALL have port core_state  output  3  current FSM state (core_state_t encoding).
REQ-012 SHALL have port current_pc  output  PC_WIDTH  fetch address.
REQ-013 SHALL have port instr_req  output  1  fetch request; instr_valid  input  1  fetch complete.
REQ-014 SHALL have port decoded_ret  input  1  the decoded instruction is RET.
REQ-015 SHALL have port lsu_busy  input  THREADS_PER_BLOCK  per-lane memory op outstanding.
REQ-016 SHALL have port next_pc  input  THREADS_PER_BLOCK*PC_WIDTH  per-lane next PC, flattened with lane 0 at the LSBs.
REQ-017 SHALL have port retired  output  16  count of retired instructions.

Function
REQ-018 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
REQ-019 In IDLE with start=1, SHALL latch block_id_q, set thread_enable=(1<<n)-1 where n=min(thread_count,THREADS_PER_BLOCK), set current_pc=0, and go to FETCH the next cycle.
REQ-020 In IDLE with start=1 and thread_count=0, SHALL go directly to DONE with thread_enable=0.
REQ-021 In FETCH, SHALL hold instr_req=1 until instr_valid=1, then go to DECODE; instr_req SHALL be 0 in all other states.
REQ-022 DECODE, REQUEST and EXECUTE SHALL each last exactly one cycle, advancing to REQUEST, WAIT and UPDATE respectively.
REQ-023 WAIT SHALL last at least one cycle and SHALL exit to EXECUTE only when (lsu_busy & thread_enable)==0; busy bits of disabled lanes SHALL be ignored.
REQ-024 In UPDATE with decoded_ret=1, SHALL go to DONE; otherwise SHALL load current_pc from the next_pc lane-0 slice and return to FETCH.
REQ-025 retired SHALL increment by 1 on every UPDATE cycle, including RET, and SHALL wrap modulo 2^16.
REQ-026 done SHALL be 1 exactly when the state is DONE, and SHALL be registered with no combinational path from any input.
REQ-027 DONE SHALL be absorbing until reset; start SHALL be ignored in every state except IDLE.
REQ-028 Inputs block_id and thread_count SHALL be sampled only at the IDLE->FETCH (or IDLE->DONE) transition; later changes SHALL have no effect.
REQ-029 current_pc SHALL wrap modulo 2^PC_WIDTH as supplied by next_pc, with no saturation.
REQ-030 Minimum instruction latency with instr_valid and lsu_busy=0 on first sample SHALL be 6 cycles (FETCH through UPDATE).

Reset
REQ-031 On reset, SHALL set the state to IDLE, done=0, instr_req=0, block_id_q=0, thread_enable=0, current_pc=0 and retired=0.
REQ-032 Reset SHALL take priority over all other conditions in any state, including mid-FETCH or mid-WAIT; an outstanding instr_valid or lsu_busy SHALL be discarded.
REQ-033 After reset deasserts with start=1, SHALL re-latch the block inputs on the next cycle as in REQ-019.

Structure
REQ-034 Package gpu_pkg SHALL hold the core_state_t enum (REQ-018 encoding) and the default PC_WIDTH.
REQ-035 SHALL be a single module with no sub-modules; the lane-mask generation SHALL be a function in gpu_pkg.

Verification
REQ-036 Scenario 1: start with thread_count=3, block_id=5, a program of 2 instructions with the second RET, instr_valid on the 1st FETCH cycle, lsu_busy=0 -> thread_enable=0111, block_id_q=5, done=1 after 12 post-latch cycles, retired=2.
REQ-037 Scenario 2: thread_count=0 -> DONE one cycle after start, thread_enable=0, instr_req never asserted.
REQ-038 Scenario 3: lsu_busy=1000 with thread_count=2 -> WAIT lasts 1 cycle; lsu_busy=0001 held for 4 cycles -> WAIT lasts 4 cycles.
REQ-039 Scenario 4: instr_valid delayed 3 cycles -> instr_req high for 4 cycles, then DECODE.
REQ-040 Scenario 5: reset asserted in WAIT -> all outputs at their reset values the next cycle; with start still high, re-latch and re-run from pc=0.
REQ-041 Scenario 6: thread_count=7 with THREADS_PER_BLOCK=4 -> thread_enable=1111; next_pc lane0=0xFF then wrap -> current_pc=0x00.
